// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// event-counter width and saturation limit.
package pipe_ctrl_pkg;

  localparam int ASIZE_DEF = 4;
  localparam int CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } ctrl_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard term: a load in ID/EXE writes a register that the ID
// instruction actually reads. Shared with the forwarding unit.
module load_use_detect #(
  parameter int ASIZE = 4
) (
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_memtoreg,
  input  logic             ex_writeenable,
  input  logic [ASIZE-1:0] ex_waddr,
  output logic             hz
);

  logic load_wr_s;
  logic rs1_match_s;
  logic rs2_match_s;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_wr_s   = ex_memtoreg & ex_writeenable & (ex_waddr != {ASIZE{1'b0}});
  assign rs1_match_s = id_rs1_used & (id_rs1 == ex_waddr);
  assign rs2_match_s = id_rs2_used & (id_rs2 == ex_waddr);
  assign hz          = load_wr_s & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences PC, IF/ID and ID/EXE for load-use stalls,
// taken-branch flushes and memory-busy freezes, and counts stall/flush events.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ASIZE             = ASIZE_DEF,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs1,
  input  logic [ASIZE-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_memtoreg,
  input  logic             ex_writeenable,
  input  logic [ASIZE-1:0] ex_waddr,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] STALL_REM = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_REM = 2'(FLUSH_CYCLES - 1);

  ctrl_state_e      state_d, state_q;
  logic [1:0]       rem_d, rem_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic             hz_s;
  logic             pc_hold_s, ifid_hold_s, ifid_flush_s, idex_hold_s, idex_bubble_s;
  logic             stall_inc_s, flush_inc_s;

  load_use_detect #(.ASIZE(ASIZE)) u_load_use_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_memtoreg   (ex_memtoreg),
    .ex_writeenable(ex_writeenable),
    .ex_waddr      (ex_waddr),
    .hz            (hz_s)
  );

  // Prioritised next-state, remaining-cycle count and control decode.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_hold_s   = 1'b0;
    idex_bubble_s = 1'b0;
    stall_inc_s   = 1'b0;
    flush_inc_s   = 1'b0;
    if (mem_busy) begin
      pc_hold_s   = 1'b1;
      ifid_hold_s = 1'b1;
      idex_hold_s = 1'b1;
    end else if (br_taken) begin
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      flush_inc_s   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        rem_d   = FLUSH_REM;
      end else begin
        state_d = RUN;
        rem_d   = 2'd0;
      end
    end else begin
      case (state_q)
        FLUSH: begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
            rem_d   = 2'd0;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        STALL: begin
          pc_hold_s     = 1'b1;
          ifid_hold_s   = 1'b1;
          idex_bubble_s = 1'b1;
          stall_inc_s   = 1'b1;
          if (rem_q == 2'd1) begin
            state_d = RUN;
            rem_d   = 2'd0;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        RUN: begin
          if (hz_s) begin
            pc_hold_s     = 1'b1;
            ifid_hold_s   = 1'b1;
            idex_bubble_s = 1'b1;
            stall_inc_s   = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              rem_d   = STALL_REM;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // Counters freeze under mem_busy even against clr_cnt; clr_cnt beats an increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_busy) begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
    end else if (clr_cnt) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else begin
      stall_cnt_d = stall_inc_s ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush_inc_s ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end
  end

  // State, remaining-cycle and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Controls are forced low for as long as reset is held.
  assign pc_hold     = rst & pc_hold_s;
  assign ifid_hold   = rst & ifid_hold_s;
  assign ifid_flush  = rst & ifid_flush_s;
  assign idex_hold   = rst & idex_hold_s;
  assign idex_bubble = rst & idex_bubble_s;
  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with LOAD_STALL_CYCLES=3, FLUSH_CYCLES=3:
// the driver queues hand-computed expectations, a negedge monitor compares them.
module tb_pipe_hazard_ctrl;

  localparam logic [4:0] C_NONE  = 5'b00000;  // {pc_hold,ifid_hold,ifid_flush,idex_hold,idex_bubble}
  localparam logic [4:0] C_STALL = 5'b11001;
  localparam logic [4:0] C_FLUSH = 5'b00101;
  localparam logic [4:0] C_BUSY  = 5'b11010;

  typedef struct {
    string       nm;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  id_rs1 = 4'd0, id_rs2 = 4'd0, ex_waddr = 4'd0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic        ex_memtoreg = 1'b0, ex_writeenable = 1'b0;
  logic        br_taken = 1'b0, mem_busy = 1'b0, clr_cnt = 1'b0;
  logic        pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t        exp_q[$];
  exp_t        e_mon;
  logic [4:0]  got_ctl;
  int          n_cmp = 0;
  int          n_bad = 0;

  pipe_hazard_ctrl #(.ASIZE(4), .LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_memtoreg(ex_memtoreg), .ex_writeenable(ex_writeenable), .ex_waddr(ex_waddr),
    .br_taken(br_taken), .mem_busy(mem_busy), .clr_cnt(clr_cnt),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_hold(idex_hold), .idex_bubble(idex_bubble),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_mon   = exp_q.pop_front();
      got_ctl = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble};
      n_cmp++;
      if (got_ctl !== e_mon.ctl || state !== e_mon.st ||
          stall_cnt !== e_mon.sc || flush_cnt !== e_mon.fc) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b state=%0d stall_cnt=%h flush_cnt=%h, expected ctl=%b state=%0d stall_cnt=%h flush_cnt=%h",
                 e_mon.nm, got_ctl, state, stall_cnt, flush_cnt, e_mon.ctl, e_mon.st, e_mon.sc, e_mon.fc);
      end
    end
  end

  task automatic drive(input logic [3:0] rs1, input logic [3:0] rs2, input logic u1, input logic u2,
                       input logic mt, input logic we, input logic [3:0] wa,
                       input logic br, input logic mb, input logic clr);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_memtoreg = mt; ex_writeenable = we; ex_waddr = wa;
    br_taken = br; mem_busy = mb; clr_cnt = clr;
  endtask

  // One cycle: apply inputs, queue what the outputs must show before the next edge.
  task automatic cyc(input string nm, input logic [3:0] rs1, input logic [3:0] rs2,
                     input logic u1, input logic u2, input logic mt, input logic we,
                     input logic [3:0] wa, input logic br, input logic mb, input logic clr,
                     input logic [4:0] ctl, input logic [1:0] st,
                     input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    drive(rs1, rs2, u1, u2, mt, we, wa, br, mb, clr);
    e.nm = nm; e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset holds everything low even with a hazard and a branch present
    cyc("reset",          4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 1, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    rst = 1'b1;
    cyc("nofs_waddr0",    4'd0, 4'd0, 1, 0, 1, 1, 4'd0, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    cyc("nofs_rs2_unused",4'd1, 4'd5, 1, 0, 1, 1, 4'd5, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    cyc("nofs_not_load",  4'd3, 4'd0, 1, 0, 0, 1, 4'd3, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    cyc("nofs_no_we",     4'd3, 4'd0, 1, 0, 1, 0, 4'd3, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    // load-use on rs1: three stall cycles
    cyc("lu_run",         4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 0, C_STALL, 2'd0, 16'd0, 16'd0);
    cyc("lu_stall1",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_STALL, 2'd1, 16'd1, 16'd0);
    cyc("lu_stall2",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_STALL, 2'd1, 16'd2, 16'd0);
    cyc("lu_done",        4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_NONE,  2'd0, 16'd3, 16'd0);
    // rs2 hazard, then branch on the second stall cycle takes over
    cyc("ov_rs2_hz",      4'd0, 4'd7, 0, 1, 1, 1, 4'd7, 0, 0, 0, C_STALL, 2'd0, 16'd3, 16'd0);
    cyc("ov_branch",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 0, C_FLUSH, 2'd1, 16'd4, 16'd0);
    cyc("ov_flush1",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_FLUSH, 2'd2, 16'd4, 16'd1);
    cyc("ov_flush2",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_FLUSH, 2'd2, 16'd4, 16'd1);
    cyc("ov_done",        4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_NONE,  2'd0, 16'd4, 16'd1);
    // branch from RUN, frozen for 4 busy cycles mid-flush, then resumes
    cyc("mf_branch",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 0, 0, C_FLUSH, 2'd0, 16'd4, 16'd1);
    cyc("mf_flush1",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_FLUSH, 2'd2, 16'd4, 16'd2);
    cyc("mf_busy0",       4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 0, C_BUSY,  2'd2, 16'd4, 16'd2);
    cyc("mf_busy_br",     4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 1, 1, 0, C_BUSY,  2'd2, 16'd4, 16'd2);
    cyc("mf_busy_hz",     4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 1, 0, C_BUSY,  2'd2, 16'd4, 16'd2);
    cyc("mf_busy_clr",    4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 1, 1, C_BUSY,  2'd2, 16'd4, 16'd2);
    cyc("mf_flush2",      4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_FLUSH, 2'd2, 16'd4, 16'd2);
    cyc("mf_done",        4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_NONE,  2'd0, 16'd4, 16'd2);
    // clr_cnt wins over a same-cycle stall increment
    cyc("clr_hz",         4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 1, C_STALL, 2'd0, 16'd4, 16'd2);
    cyc("clr_stall1",     4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_STALL, 2'd1, 16'd0, 16'd0);
    cyc("clr_stall2",     4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_STALL, 2'd1, 16'd1, 16'd0);
    cyc("clr_done",       4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 1, C_NONE,  2'd0, 16'd2, 16'd0);
    // 65535 hazard cycles fill the stall counter; 65535 is a multiple of 3, so RUN again
    for (int i = 0; i < 65535; i++) begin
      drive(4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    cyc("sat_run",        4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 0, C_STALL, 2'd0, 16'hFFFF, 16'd0);
    cyc("sat_stall",      4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 0, C_STALL, 2'd1, 16'hFFFF, 16'd0);
    // asynchronous reset in the middle of the stall
    rst = 1'b0;
    cyc("rst_mid_stall",  4'd3, 4'd0, 1, 0, 1, 1, 4'd3, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    rst = 1'b1;
    cyc("post_reset",     4'd0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0, 0, C_NONE,  2'd0, 16'd0, 16'd0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
